// File: rtl/fix_checksum_trailer.sv
// fix_checksum_trailer
//   Sits behind the FIX message-creation FSM. Body bytes are forwarded one
//   cycle after acceptance while a mod-256 CheckSum is accumulated. After the
//   last body byte the block appends the trailer "10=DDD<SOH>" and reports the
//   checksum and body length to the session layer.
// Ports:
//   clk, rst          clock (posedge) and synchronous active-high reset
//   data_i            body byte from the message-creation FSM
//   data_valid_i      data_i valid this cycle
//   sof_i / eom_i     first / last body byte markers (qualified by data_valid_i)
//   ready_o           high while body bytes can be accepted (IDLE, BODY)
//   data_o            forwarded body byte or trailer byte
//   data_valid_o      data_o valid (downstream never stalls)
//   checksum_o        final sum mod 256, with checksum_valid_o
//   len_o             body bytes of the current message, saturating
//   abort_o           pulse when a new sof_i restarts a message in BODY
//   done_o            pulse aligned with the SOH trailer byte
module fix_checksum_trailer #(
  parameter logic [7:0] SOH_CHAR = 8'h01,
  parameter int         LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  input  logic             sof_i,
  input  logic             eom_i,
  output logic             ready_o,
  output logic [7:0]       data_o,
  output logic             data_valid_o,
  output logic [7:0]       checksum_o,
  output logic             checksum_valid_o,
  output logic [LEN_W-1:0] len_o,
  output logic             abort_o,
  output logic             done_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_BODY = 4'd1,
    S_CALC = 4'd2,
    S_T1   = 4'd3,
    S_T0   = 4'd4,
    S_TEQ  = 4'd5,
    S_TD2  = 4'd6,
    S_TD1  = 4'd7,
    S_TD0  = 4'd8,
    S_TSOH = 4'd9
  } state_t;

  // Splits a byte into hundreds/tens/units with compares and subtracts only.
  function automatic logic [11:0] to_dec3(input logic [7:0] v);
    logic [7:0] r;
    logic [3:0] h;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 8'd200) begin
      h = 4'd2;
      r = r - 8'd200;
    end else if (r >= 8'd100) begin
      h = 4'd1;
      r = r - 8'd100;
    end else begin
      h = 4'd0;
    end
    for (int i = 0; i < 9; i++) begin
      if (r >= 8'd10) begin
        r = r - 8'd10;
        t = t + 4'd1;
      end else begin
        r = r;
      end
    end
    return {h, t, r[3:0]};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       sum_q, sum_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic [7:0]       checksum_q, checksum_d;
  logic             checksum_valid_q, checksum_valid_d;
  logic             abort_q, abort_d;
  logic             done_q, done_d;
  logic [3:0]       d2_q, d2_d;
  logic [3:0]       d1_q, d1_d;
  logic [3:0]       d0_q, d0_d;
  logic             ready_s;
  logic             accept_s;

  assign ready_s  = (state_q == S_IDLE) || (state_q == S_BODY);
  assign accept_s = data_valid_i & ready_s;

  // Next-state and next-output logic; trailer bytes are loaded one state
  // ahead so each appears on data_o while the FSM sits in its named state.
  always_comb begin
    state_d          = state_q;
    sum_d            = sum_q;
    len_d            = len_q;
    data_d           = data_q;
    data_valid_d     = 1'b0;
    checksum_d       = checksum_q;
    checksum_valid_d = checksum_valid_q;
    abort_d          = 1'b0;
    done_d           = 1'b0;
    d2_d             = d2_q;
    d1_d             = d1_q;
    d0_d             = d0_q;
    case (state_q)
      S_IDLE, S_BODY: begin
        if (accept_s && sof_i) begin
          // New message (or restart of one in progress).
          sum_d            = data_i;
          len_d            = LEN_W'(1);
          checksum_valid_d = 1'b0;
          data_d           = data_i;
          data_valid_d     = 1'b1;
          abort_d          = (state_q == S_BODY);
          state_d          = eom_i ? S_CALC : S_BODY;
        end else if (accept_s && (state_q == S_BODY)) begin
          sum_d        = sum_q + data_i;
          len_d        = (&len_q) ? len_q : (len_q + LEN_W'(1));
          data_d       = data_i;
          data_valid_d = 1'b1;
          state_d      = eom_i ? S_CALC : S_BODY;
        end else begin
          // Idle cycle, or a stray non-sof byte in IDLE which is dropped.
          state_d = state_q;
        end
      end
      S_CALC: begin
        checksum_d           = sum_q;
        checksum_valid_d     = 1'b1;
        {d2_d, d1_d, d0_d}   = to_dec3(sum_q);
        data_d               = 8'h31;
        data_valid_d         = 1'b1;
        state_d              = S_T1;
      end
      S_T1: begin
        data_d       = 8'h30;
        data_valid_d = 1'b1;
        state_d      = S_T0;
      end
      S_T0: begin
        data_d       = 8'h3D;
        data_valid_d = 1'b1;
        state_d      = S_TEQ;
      end
      S_TEQ: begin
        data_d       = 8'h30 + {4'd0, d2_q};
        data_valid_d = 1'b1;
        state_d      = S_TD2;
      end
      S_TD2: begin
        data_d       = 8'h30 + {4'd0, d1_q};
        data_valid_d = 1'b1;
        state_d      = S_TD1;
      end
      S_TD1: begin
        data_d       = 8'h30 + {4'd0, d0_q};
        data_valid_d = 1'b1;
        state_d      = S_TD0;
      end
      S_TD0: begin
        data_d       = SOH_CHAR;
        data_valid_d = 1'b1;
        done_d       = 1'b1;
        state_d      = S_TSOH;
      end
      S_TSOH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      sum_q            <= 8'd0;
      len_q            <= '0;
      data_q           <= 8'd0;
      data_valid_q     <= 1'b0;
      checksum_q       <= 8'd0;
      checksum_valid_q <= 1'b0;
      abort_q          <= 1'b0;
      done_q           <= 1'b0;
      d2_q             <= 4'd0;
      d1_q             <= 4'd0;
      d0_q             <= 4'd0;
    end else begin
      state_q          <= state_d;
      sum_q            <= sum_d;
      len_q            <= len_d;
      data_q           <= data_d;
      data_valid_q     <= data_valid_d;
      checksum_q       <= checksum_d;
      checksum_valid_q <= checksum_valid_d;
      abort_q          <= abort_d;
      done_q           <= done_d;
      d2_q             <= d2_d;
      d1_q             <= d1_d;
      d0_q             <= d0_d;
    end
  end

  assign ready_o          = ready_s;
  assign data_o           = data_q;
  assign data_valid_o     = data_valid_q;
  assign checksum_o       = checksum_q;
  assign checksum_valid_o = checksum_valid_q;
  assign len_o            = len_q;
  assign abort_o          = abort_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_fix_checksum_trailer.sv
module tb_fix_checksum_trailer;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       data_i;
  logic             data_valid_i;
  logic             sof_i;
  logic             eom_i;
  logic             ready_o;
  logic [7:0]       data_o;
  logic             data_valid_o;
  logic [7:0]       checksum_o;
  logic             checksum_valid_o;
  logic [LEN_W-1:0] len_o;
  logic             abort_o;
  logic             done_o;

  fix_checksum_trailer #(.SOH_CHAR(8'h01), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
    .sof_i(sof_i), .eom_i(eom_i), .ready_o(ready_o), .data_o(data_o),
    .data_valid_o(data_valid_o), .checksum_o(checksum_o),
    .checksum_valid_o(checksum_valid_o), .len_o(len_o), .abort_o(abort_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed output stream and pulse counts.
  logic [7:0] obs_q[$];
  int done_cnt = 0;
  int abort_cnt = 0;
  int done_bad = 0;

  // Reference model state (message level).
  logic [7:0] exp_q[$];
  logic [7:0] cur_body[$];
  bit         msg_active = 1'b0;
  logic [7:0] exp_ck = 8'd0;
  int         exp_len = 0;
  int         exp_done = 0;
  int         exp_abort = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid_o) obs_q.push_back(data_o);
      if (done_o) begin
        done_cnt++;
        if (!(data_valid_o && data_o == 8'h01)) done_bad++;
      end
      if (abort_o) abort_cnt++;
    end
  end

  function automatic string q2str(input logic [7:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Model: a message is every byte from an accepted sof to eom; it is echoed,
  // then followed by "10=" + three decimal digits of its byte sum mod 256 + SOH.
  task automatic model_accept(input logic [7:0] b, input logic s, input logic e);
    int sum;
    if (!msg_active && !s) return;
    if (s) begin
      if (msg_active) exp_abort++;
      cur_body.delete();
    end
    msg_active = 1'b1;
    cur_body.push_back(b);
    exp_q.push_back(b);
    if (e) begin
      sum = 0;
      foreach (cur_body[i]) sum += int'(cur_body[i]);
      sum = sum % 256;
      exp_ck  = 8'(sum);
      exp_len = cur_body.size();
      exp_q.push_back(8'h31);
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h3D);
      exp_q.push_back(8'(48 + sum / 100));
      exp_q.push_back(8'(48 + (sum / 10) % 10));
      exp_q.push_back(8'(48 + sum % 10));
      exp_q.push_back(8'h01);
      exp_done++;
      msg_active = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s, input logic e);
    int n;
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready_o=%0b required 1", ready_o);
    end else begin
      data_i = b; sof_i = s; eom_i = e; data_valid_i = 1'b1;
      @(posedge clk); #1;
      data_valid_i = 1'b0; sof_i = 1'b0; eom_i = 1'b0;
      model_accept(b, s, e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_streams();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid_i = 1'b0; sof_i = 1'b0; eom_i = 1'b0; data_i = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks += 8;
    if (data_o !== 8'd0)           begin errors++; $display("FAIL rst_data: got %h want 00", data_o); end
    if (data_valid_o !== 1'b0)     begin errors++; $display("FAIL rst_valid: got %b want 0", data_valid_o); end
    if (ready_o !== 1'b1)          begin errors++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    if (checksum_o !== 8'd0)       begin errors++; $display("FAIL rst_ck: got %h want 00", checksum_o); end
    if (checksum_valid_o !== 1'b0) begin errors++; $display("FAIL rst_ckv: got %b want 0", checksum_valid_o); end
    if (len_o !== '0)              begin errors++; $display("FAIL rst_len: got %0d want 0", len_o); end
    if (abort_o !== 1'b0)          begin errors++; $display("FAIL rst_abort: got %b want 0", abort_o); end
    if (done_o !== 1'b0)           begin errors++; $display("FAIL rst_done: got %b want 0", done_o); end
  endtask

  task automatic test_basic();
    string want;
    clear_streams();
    send_byte(8'h31, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b1);
    wait_idle();
    want = "31 01 31 30 3d 30 35 30 01 ";
    checks += 5;
    if (q2str(obs_q) != want) begin errors++; $display("FAIL basic_stream: got %s want %s", q2str(obs_q), want); end
    if (checksum_o !== 8'h32) begin errors++; $display("FAIL basic_ck: got %h want 32", checksum_o); end
    if (checksum_valid_o !== 1'b1) begin errors++; $display("FAIL basic_ckv: got %b want 1", checksum_valid_o); end
    if (len_o !== 16'd2) begin errors++; $display("FAIL basic_len: got %0d want 2", len_o); end
    if (done_cnt != exp_done || done_bad != 0) begin errors++; $display("FAIL basic_done: got %0d/%0d want %0d/0", done_cnt, done_bad, exp_done); end
  endtask

  task automatic test_wrap();
    clear_streams();
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b1);
    wait_idle();
    checks += 3;
    if (q2str(obs_q) != q2str(exp_q)) begin errors++; $display("FAIL wrap_stream: got %s want %s", q2str(obs_q), q2str(exp_q)); end
    if (checksum_o !== 8'h01) begin errors++; $display("FAIL wrap_ck: got %h want 01", checksum_o); end
    if (len_o !== 16'd3) begin errors++; $display("FAIL wrap_len: got %0d want 3", len_o); end
  endtask

  task automatic test_single_timing();
    clear_streams();
    send_byte(8'hC8, 1'b1, 1'b1);
    checks += 2;
    if (!(data_valid_o === 1'b1 && data_o === 8'hC8 && ready_o === 1'b0)) begin
      errors++; $display("FAIL single_calc: got v=%b d=%h rdy=%b want 1 c8 0", data_valid_o, data_o, ready_o);
    end
    @(posedge clk); #1;
    if (!(data_valid_o === 1'b1 && data_o === 8'h31)) begin
      errors++; $display("FAIL single_t1: got v=%b d=%h want 1 31", data_valid_o, data_o);
    end
    wait_idle();
    checks += 3;
    if (q2str(obs_q) != "c8 31 30 3d 32 30 30 01 ") begin errors++; $display("FAIL single_stream: got %s", q2str(obs_q)); end
    if (checksum_o !== 8'd200) begin errors++; $display("FAIL single_ck: got %0d want 200", checksum_o); end
    if (len_o !== 16'd1) begin errors++; $display("FAIL single_len: got %0d want 1", len_o); end
  endtask

  task automatic test_busy_ignore();
    int busy_bad;
    clear_streams();
    send_byte(8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    send_byte(8'($urandom), 1'b0, 1'b1);
    busy_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready_o !== 1'b0) busy_bad++;
      data_i = 8'($urandom); sof_i = 1'($urandom); eom_i = 1'($urandom); data_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    data_valid_i = 1'b0; sof_i = 1'b0; eom_i = 1'b0;
    wait_idle();
    checks += 4;
    if (busy_bad != 0) begin errors++; $display("FAIL busy_ready: got %0d high cycles want 0", busy_bad); end
    if (q2str(obs_q) != q2str(exp_q)) begin errors++; $display("FAIL busy_stream: got %s want %s", q2str(obs_q), q2str(exp_q)); end
    if (checksum_o !== exp_ck) begin errors++; $display("FAIL busy_ck: got %h want %h", checksum_o, exp_ck); end
    if (len_o !== 16'd5) begin errors++; $display("FAIL busy_len: got %0d want 5", len_o); end
  endtask

  task automatic test_abort();
    int a0;
    clear_streams();
    a0 = abort_cnt;
    send_byte(8'h41, 1'b1, 1'b0);
    send_byte(8'h42, 1'b0, 1'b0);
    send_byte(8'h43, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b1);
    wait_idle();
    checks += 4;
    if (abort_cnt - a0 != 1) begin errors++; $display("FAIL abort_pulse: got %0d want 1", abort_cnt - a0); end
    if (checksum_o !== 8'h44) begin errors++; $display("FAIL abort_ck: got %h want 44", checksum_o); end
    if (len_o !== 16'd2) begin errors++; $display("FAIL abort_len: got %0d want 2", len_o); end
    if (q2str(obs_q) != q2str(exp_q)) begin errors++; $display("FAIL abort_stream: got %s want %s", q2str(obs_q), q2str(exp_q)); end
  endtask

  task automatic test_reset_mid();
    int n_obs;
    int n_done;
    clear_streams();
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h66, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checks += 1;
    if (!(data_valid_o === 1'b1 && data_o === 8'h38)) begin
      errors++; $display("FAIL rmid_td1: got v=%b d=%h want 1 38", data_valid_o, data_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 4;
    if (data_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", data_valid_o); end
    if (ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", ready_o); end
    if (checksum_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_ckv: got %b want 0", checksum_valid_o); end
    if (done_o !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done_o); end
    rst = 1'b0;
    msg_active = 1'b0;
    exp_done--;
    n_obs = obs_q.size();
    n_done = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    checks += 1;
    if (obs_q.size() != n_obs || done_cnt != n_done) begin
      errors++; $display("FAIL rmid_quiet: got %0d bytes %0d done after reset want 0 0", obs_q.size() - n_obs, done_cnt - n_done);
    end
  endtask

  task automatic test_random();
    int len;
    for (int m = 0; m < 8; m++) begin
      clear_streams();
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) send_byte(8'($urandom), 1'b0, 1'b0);
      len = int'($urandom_range(1, 20));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          data_valid_i = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_byte(8'($urandom), (k == 0) || ($urandom_range(0, 7) == 0), k == len - 1);
      end
      wait_idle();
      checks += 6;
      if (q2str(obs_q) != q2str(exp_q)) begin errors++; $display("FAIL rnd_stream: got %s want %s", q2str(obs_q), q2str(exp_q)); end
      if (checksum_o !== exp_ck) begin errors++; $display("FAIL rnd_ck: got %h want %h", checksum_o, exp_ck); end
      if (len_o !== LEN_W'(exp_len)) begin errors++; $display("FAIL rnd_len: got %0d want %0d", len_o, exp_len); end
      if (checksum_valid_o !== 1'b1) begin errors++; $display("FAIL rnd_ckv: got %b want 1", checksum_valid_o); end
      if (done_cnt != exp_done || done_bad != 0) begin errors++; $display("FAIL rnd_done: got %0d/%0d want %0d/0", done_cnt, done_bad, exp_done); end
      if (abort_cnt != exp_abort) begin errors++; $display("FAIL rnd_abort: got %0d want %0d", abort_cnt, exp_abort); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_single_timing();
    test_busy_ignore();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
